// File: rtl/mips_cpu_state_sequencer.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXECk stepping, memory and
// mul/div interlocks, and the pc==0 halt.
module mips_cpu_state_sequencer #(
   parameter int unsigned LOAD_STAGES   = 2,
   parameter int unsigned MULDIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        waitrequest,
   input  logic [5:0]  opcode,
   input  logic [5:0]  fncode,
   input  logic [4:0]  regimm,
   input  logic [31:0] pc,
   output logic [2:0]  state,
   output logic        active,
   output logic        stall,
   output logic        muldiv_busy
);

   localparam int unsigned STATE_W = 3;
   localparam int unsigned CNT_W   = 6;

   typedef enum logic [STATE_W-1:0] {
      S_HALT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC1  = 3'd3,
      S_EXEC2  = 3'd4,
      S_EXEC3  = 3'd5,
      S_EXEC4  = 3'd6
   } state_e;

   state_e             state_q, state_d;
   logic               active_q, active_d;
   logic               busy_q, busy_d;
   logic               first_q, first_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               is_special, is_lw, is_muldiv, is_hilo;
   logic [STATE_W-1:0] n_stages, exec_k;
   logic               halt_now, fetch_hold, exec_hold;

   // Instruction class, stage count and hold conditions
   always_comb begin
      is_special = (opcode == 6'h00);
      is_lw      = (opcode == 6'h23);
      is_muldiv  = is_special && (fncode[5:2] == 4'b0110);
      is_hilo    = is_special && (fncode[5:2] == 4'b0100);
      n_stages   = 3'd1;
      if (is_lw) begin
         n_stages = STATE_W'(LOAD_STAGES);
      end else if ((opcode == 6'h01) && ((regimm == 5'h10) || (regimm == 5'h11))) begin
         n_stages = 3'd2;
      end
      exec_k     = STATE_W'(state_q) - 3'd2;
      // pc is only inspected on the first cycle of each FETCH
      halt_now   = first_q && (pc == 32'h0);
      fetch_hold = waitrequest && !halt_now;
      exec_hold  = (is_lw && waitrequest) || (is_hilo && busy_q);
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_FETCH;
         active_q <= 1'b1;
         busy_q   <= 1'b0;
         first_q  <= 1'b1;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         busy_q   <= busy_d;
         first_q  <= first_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next state and registered-output values
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_HALT:   state_d = S_HALT;
         S_FETCH: begin
            if (halt_now)          state_d = S_HALT;
            else if (!waitrequest) state_d = S_DECODE;
         end
         S_DECODE: state_d = S_EXEC1;
         S_EXEC1: begin
            if (!exec_hold) state_d = (exec_k < n_stages) ? S_EXEC2 : S_FETCH;
         end
         S_EXEC2:  state_d = (exec_k < n_stages) ? S_EXEC3 : S_FETCH;
         S_EXEC3:  state_d = (exec_k < n_stages) ? S_EXEC4 : S_FETCH;
         S_EXEC4:  state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase

      // A new mul/div restarts the countdown; otherwise it drains to zero
      if ((state_q == S_EXEC1) && is_muldiv && !exec_hold) begin
         cnt_d = CNT_W'(MULDIV_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end

      active_d = (state_d != S_HALT);
      busy_d   = (cnt_d != '0) && (state_d != S_HALT);
      first_d  = (state_d == S_FETCH) && (state_q != S_FETCH);
   end

   // Outputs
   always_comb begin
      stall = 1'b0;
      if (!reset) begin
         stall = ((state_q == S_FETCH) && fetch_hold) ||
                 ((state_q == S_EXEC1) && exec_hold);
      end
   end

   assign state       = STATE_W'(state_q);
   assign active      = active_q;
   assign muldiv_busy = busy_q;

endmodule
